// File: rtl/rvv_pkg.sv
// Shared definitions for the RVV ALU sequencer: operand-type codes, supported funct6 values,
// the sequencer state encoding and the chunks-per-element helper.
package rvv_pkg;

   localparam logic [2:0] OpTypeVV = 3'b001;
   localparam logic [2:0] OpTypeVX = 3'b010;
   localparam logic [2:0] OpTypeVI = 3'b100;

   localparam logic [5:0] F6Vadd   = 6'b000000;
   localparam logic [5:0] F6Vsub   = 6'b000010;
   localparam logic [5:0] F6Vand   = 6'b001001;
   localparam logic [5:0] F6Vor    = 6'b001010;
   localparam logic [5:0] F6Vxor   = 6'b001011;
   localparam logic [5:0] F6Vmandn = 6'b011000;
   localparam logic [5:0] F6Vmand  = 6'b011001;
   localparam logic [5:0] F6Vmor   = 6'b011010;
   localparam logic [5:0] F6Vmxor  = 6'b011011;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StRun,
      StDone
   } seq_state_e;

   // Number of lane-wide chunks needed to cover one element of width 2^(vsew+3).
   function automatic int unsigned calc_chunks(input logic [2:0] vsew,
                                               input int unsigned lane_width);
      int unsigned sew_log;
      sew_log = 32'(vsew) + 32'd3;
      return (sew_log <= lane_width) ? 32'd1 : (32'd1 << (sew_log - lane_width));
   endfunction

endpackage

// File: rtl/rvv_vd_merge.sv
// Per-lane write of one LW-bit result chunk into the destination image: produces a bit
// mask and aligned data for positions [index, index+LW) that lie below the bit limit.
module rvv_vd_merge #(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3,
   parameter int unsigned LimW       = 8
) (
   input  logic [(1<<LANE_WIDTH)-1:0] lane_vd_i,
   input  logic [9:0]                 lane_index_i,
   input  logic                       en_i,
   input  logic [LimW-1:0]            limit_i,
   output logic [VLEN-1:0]            wr_mask_o,
   output logic [VLEN-1:0]            wr_data_o
);

   localparam int unsigned LW = 1 << LANE_WIDTH;

   logic [31:0] base;
   logic [31:0] lim;

   assign base = 32'(lane_index_i);
   assign lim  = 32'(limit_i);

   always_comb begin
      wr_mask_o = '0;
      wr_data_o = '0;
      for (int unsigned b = 0; b < VLEN; b++) begin
         if (en_i && (b >= base) && ((b - base) < LW) && (b < lim)) begin
            wr_mask_o[b] = 1'b1;
            wr_data_o[b] = lane_vd_i[LANE_WIDTH'(b - base)];
         end
      end
   end

endmodule

// File: rtl/rvv_alu_seq.sv
// Sequencer for the rvv_alu lane array: steps elements and LANE-wide sub-chunks through the
// lanes, merges the lane results into a tail-undisturbed destination image and returns vd.
module rvv_alu_seq
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3,
   parameter int unsigned MAX_LANES  = 4,
   localparam int unsigned VlW       = $clog2(VLEN) + 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [5:0]              opcode,
   input  logic                    instr_mask,
   input  logic [2:0]              vsew,
   input  logic [2:0]              op_type,
   input  logic [1:0]              nb_lanes,
   input  logic [VlW-1:0]          vl,
   input  logic [VLEN-1:0]         vs1_in,
   input  logic [VLEN-1:0]         vs2_in,
   input  logic [VLEN-1:0]         vd_old,
   output logic [VLEN-1:0]         alu_vs1,
   output logic [VLEN-1:0]         alu_vs2,
   output logic [5:0]              alu_opcode,
   output logic [2:0]              alu_vsew,
   output logic [2:0]              alu_op_type,
   output logic [1:0]              alu_nb_lanes,
   output logic                    alu_instr_mask,
   output logic                    alu_run,
   output logic [9:0]              alu_byte_i,
   output logic [3:0]              alu_in_reg_offset,
   input  logic [64*MAX_LANES-1:0] lane_vd,
   input  logic [10*MAX_LANES-1:0] lane_index,
   input  logic [MAX_LANES-1:0]    lane_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [VLEN-1:0]         vd_out
);

   localparam int unsigned LW       = 1 << LANE_WIDTH;
   localparam int unsigned LogLanes = $clog2(MAX_LANES);
   localparam logic [2:0]  MaskVsew = 3'(LANE_WIDTH - 3);

   seq_state_e state_q, state_d;

   logic [5:0]      opcode_q;
   logic [2:0]      vsew_q, op_type_q;
   logic [1:0]      nb_lanes_q;
   logic            mask_q;
   logic [VLEN-1:0] vs1_q, vs2_q;
   logic [VlW-1:0]  vl_q, ne_q;
   logic [3:0]      ch_last_q;
   logic [VLEN-1:0] acc_q, acc_d, vd_out_q, vd_out_d;
   logic [9:0]      byte_q, byte_d;
   logic [3:0]      offset_q, offset_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d, err_pend_q, err_pend_d;

   logic            latch_en;
   logic [2:0]      in_vsew;
   logic [3:0]      in_ch_last;
   logic [VlW:0]    vl_round;
   logic [VlW-1:0]  in_ne;

   assign latch_en   = (state_q == StIdle) && start;
   assign in_vsew    = instr_mask ? MaskVsew : vsew;
   assign in_ch_last = instr_mask ? 4'd0 : 4'(calc_chunks(vsew, LANE_WIDTH) - 32'd1);
   // Mask ops walk the bit vector one lane-width "element" at a time.
   assign vl_round   = {1'b0, vl} + (VlW+1)'(LW - 1);
   assign in_ne      = instr_mask ? VlW'(vl_round >> LANE_WIDTH) : vl;

   logic [31:0]          nl;
   logic [VlW-1:0]       limit;
   logic [MAX_LANES-1:0] lane_en;
   logic                 last_step;
   logic                 chk_err;

   assign nl        = 32'd1 << nb_lanes_q;
   assign limit     = mask_q ? vl_q : VlW'(VLEN);
   assign last_step = ((32'(byte_q) + nl) >= 32'(ne_q)) && (offset_q == ch_last_q);

   always_comb begin
      lane_en = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         lane_en[i] = (state_q == StRun) && (i < nl) && ((32'(byte_q) + i) < 32'(ne_q));
      end
   end

   logic [VLEN-1:0] wr_mask [MAX_LANES];
   logic [VLEN-1:0] wr_data [MAX_LANES];
   logic [VLEN-1:0] merge_mask, merge_data;

   for (genvar g = 0; g < MAX_LANES; g++) begin : g_merge
      rvv_vd_merge #(
         .VLEN       (VLEN),
         .LANE_WIDTH (LANE_WIDTH),
         .LimW       (VlW)
      ) u_merge (
         .lane_vd_i    (lane_vd[64*g +: LW]),
         .lane_index_i (lane_index[10*g +: 10]),
         .en_i         (lane_en[g]),
         .limit_i      (limit),
         .wr_mask_o    (wr_mask[g]),
         .wr_data_o    (wr_data[g])
      );
   end

   always_comb begin
      merge_mask = '0;
      merge_data = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         merge_mask = merge_mask | wr_mask[i];
         merge_data = merge_data | wr_data[i];
      end
   end

   assign chk_err = (vsew_q > 3'd3) ||
                    (32'(nb_lanes_q) > LogLanes) ||
                    (!mask_q && (32'(vl_q) > (VLEN >> (32'(vsew_q) + 32'd3)))) ||
                    (mask_q && (32'(vl_q) > VLEN)) ||
                    !lane_valid[0];

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      vd_out_d   = vd_out_q;
      byte_d     = byte_q;
      offset_d   = offset_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      err_pend_d = err_pend_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d      = vd_old;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               err_pend_d = 1'b0;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            byte_d   = '0;
            offset_d = '0;
            if (chk_err) begin
               err_pend_d = 1'b1;
               state_d    = StDone;
            end else if (vl_q == '0) begin
               state_d = StDone;
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            acc_d = (acc_q & ~merge_mask) | merge_data;
            if (offset_q < ch_last_q) begin
               offset_d = offset_q + 4'd1;
            end else begin
               offset_d = '0;
               byte_d   = byte_q + 10'(nl);
            end
            if (last_step) begin
               byte_d  = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            done_d   = 1'b1;
            vd_out_d = acc_q;
            err_d    = err_pend_q;
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= StIdle;
         opcode_q   <= '0;
         vsew_q     <= '0;
         op_type_q  <= '0;
         nb_lanes_q <= '0;
         mask_q     <= 1'b0;
         vs1_q      <= '0;
         vs2_q      <= '0;
         vl_q       <= '0;
         ne_q       <= '0;
         ch_last_q  <= '0;
         acc_q      <= '0;
         vd_out_q   <= '0;
         byte_q     <= '0;
         offset_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         vd_out_q   <= vd_out_d;
         byte_q     <= byte_d;
         offset_q   <= offset_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
         if (latch_en) begin
            opcode_q   <= opcode;
            vsew_q     <= in_vsew;
            op_type_q  <= op_type;
            nb_lanes_q <= nb_lanes;
            mask_q     <= instr_mask;
            vs1_q      <= vs1_in;
            vs2_q      <= vs2_in;
            vl_q       <= vl;
            ne_q       <= in_ne;
            ch_last_q  <= in_ch_last;
         end
      end
   end

   // Only the low LW bits of each lane result and lane 0's valid are consumed.
   logic unused_lane;
   assign unused_lane = ^{lane_vd, lane_valid};

   assign alu_vs1           = vs1_q;
   assign alu_vs2           = vs2_q;
   assign alu_opcode        = opcode_q;
   assign alu_vsew          = vsew_q;
   assign alu_op_type       = op_type_q;
   assign alu_nb_lanes      = nb_lanes_q;
   assign alu_instr_mask    = mask_q;
   assign alu_run           = (state_q == StRun);
   assign alu_byte_i        = byte_q;
   assign alu_in_reg_offset = offset_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign err               = err_q;
   assign vd_out            = vd_out_q;

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Bench for rvv_alu_seq: a behavioural lane array answers the sequencer, a vector table
// plus a scoreboard checks latency, err and vd_out, and hand sequences cover abort/ignore.
module tb_rvv_alu_seq;
   import rvv_pkg::*;

   localparam int unsigned VLEN       = 128;
   localparam int unsigned LANE_WIDTH = 3;
   localparam int unsigned MAX_LANES  = 4;
   localparam int unsigned LW         = 8;
   localparam int unsigned VlW        = 8;

   logic                    clk, resetn, start, instr_mask;
   logic [5:0]              opcode;
   logic [2:0]              vsew, op_type;
   logic [1:0]              nb_lanes;
   logic [VlW-1:0]          vl;
   logic [VLEN-1:0]         vs1_in, vs2_in, vd_old;
   logic [VLEN-1:0]         alu_vs1, alu_vs2;
   logic [5:0]              alu_opcode;
   logic [2:0]              alu_vsew, alu_op_type;
   logic [1:0]              alu_nb_lanes;
   logic                    alu_instr_mask, alu_run;
   logic [9:0]              alu_byte_i;
   logic [3:0]              alu_in_reg_offset;
   logic [64*MAX_LANES-1:0] lane_vd;
   logic [10*MAX_LANES-1:0] lane_index;
   logic [MAX_LANES-1:0]    lane_valid;
   logic                    busy, done, err;
   logic [VLEN-1:0]         vd_out;

   rvv_alu_seq #(
      .VLEN       (VLEN),
      .LANE_WIDTH (LANE_WIDTH),
      .MAX_LANES  (MAX_LANES)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .start             (start),
      .opcode            (opcode),
      .instr_mask        (instr_mask),
      .vsew              (vsew),
      .op_type           (op_type),
      .nb_lanes          (nb_lanes),
      .vl                (vl),
      .vs1_in            (vs1_in),
      .vs2_in            (vs2_in),
      .vd_old            (vd_old),
      .alu_vs1           (alu_vs1),
      .alu_vs2           (alu_vs2),
      .alu_opcode        (alu_opcode),
      .alu_vsew          (alu_vsew),
      .alu_op_type       (alu_op_type),
      .alu_nb_lanes      (alu_nb_lanes),
      .alu_instr_mask    (alu_instr_mask),
      .alu_run           (alu_run),
      .alu_byte_i        (alu_byte_i),
      .alu_in_reg_offset (alu_in_reg_offset),
      .lane_vd           (lane_vd),
      .lane_index        (lane_index),
      .lane_valid        (lane_valid),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .vd_out            (vd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic lane_ok(input logic [5:0] op, input logic msk);
      if (msk) return (op == F6Vmandn) || (op == F6Vmand) || (op == F6Vmor) || (op == F6Vmxor);
      return (op == F6Vadd) || (op == F6Vsub) || (op == F6Vand) || (op == F6Vor) ||
             (op == F6Vxor);
   endfunction

   function automatic logic [7:0] get8(input logic [VLEN-1:0] v, input int unsigned pos);
      logic [VLEN-1:0] t;
      t = v >> pos;
      return t[7:0];
   endfunction

   // Behavioural lane array: byte-wide lanes with a carry/borrow chained across chunks.
   logic [MAX_LANES-1:0] carry_q, cout;
   initial carry_q = '0;

   always_comb begin
      int unsigned e, sew, pos;
      logic [7:0]  a, b;
      logic [8:0]  s;
      logic        cin;
      lane_vd    = '0;
      lane_index = '0;
      lane_valid = '0;
      cout       = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         e   = 32'(alu_byte_i) + 32'(i);
         sew = 32'd8 << alu_vsew;
         pos = e * sew + 32'(alu_in_reg_offset) * LW;
         a   = get8(alu_vs2, pos);
         b   = get8(alu_vs1, pos);
         cin = (alu_in_reg_offset == 4'd0) ? (!alu_instr_mask && alu_opcode == F6Vsub)
                                           : carry_q[i];
         s   = '0;
         if (alu_instr_mask) begin
            case (alu_opcode)
               F6Vmandn: s = {1'b0, a & ~b};
               F6Vmand:  s = {1'b0, a & b};
               F6Vmor:   s = {1'b0, a | b};
               F6Vmxor:  s = {1'b0, a ^ b};
               default:  s = '0;
            endcase
         end else begin
            case (alu_opcode)
               F6Vadd:  s = {1'b0, a} + {1'b0, b} + 9'(cin);
               F6Vsub:  s = {1'b0, a} + {1'b0, ~b} + 9'(cin);
               F6Vand:  s = {1'b0, a & b};
               F6Vor:   s = {1'b0, a | b};
               F6Vxor:  s = {1'b0, a ^ b};
               default: s = '0;
            endcase
         end
         lane_vd[64*i +: 8]    = s[7:0];
         cout[i]               = s[8];
         lane_index[10*i +: 10] = 10'(pos);
         lane_valid[i]         = lane_ok(alu_opcode, alu_instr_mask);
      end
   end

   always @(posedge clk) if (alu_run) carry_q <= cout;

   typedef struct {
      int              id;
      logic [5:0]      op;
      logic            msk;
      logic [2:0]      sew;
      logic [1:0]      nbl;
      logic [VlW-1:0]  vl;
      logic [VLEN-1:0] vs1, vs2, old;
      logic            exp_err;
      int unsigned     exp_lat;
      logic [VLEN-1:0] exp_vd;
   } vec_t;

   function automatic logic ref_err(input vec_t v);
      if (!v.msk && v.sew > 3'd3) return 1'b1;
      if (v.nbl > 2'd2) return 1'b1;
      if (v.msk && 32'(v.vl) > VLEN) return 1'b1;
      if (!v.msk && 32'(v.vl) > VLEN / (32'd8 << v.sew)) return 1'b1;
      return !lane_ok(v.op, v.msk);
   endfunction

   function automatic int unsigned ref_lat(input vec_t v);
      int unsigned ch, ne, nl;
      if (ref_err(v) || v.vl == '0) return 2;
      ch = v.msk ? 1 : (((32'd8 << v.sew) / LW) > 0 ? (32'd8 << v.sew) / LW : 1);
      ne = v.msk ? (32'(v.vl) + LW - 1) / LW : 32'(v.vl);
      nl = 32'd1 << v.nbl;
      return 2 + ch * ((ne + nl - 1) / nl);
   endfunction

   function automatic logic [VLEN-1:0] ref_vd(input vec_t v);
      logic [VLEN-1:0] vd;
      logic [63:0]     a, b, r;
      int              sew;
      vd = v.old;
      if (ref_err(v) || v.vl == '0) return vd;
      if (v.msk) begin
         for (int k = 0; k < int'(v.vl); k++) begin
            case (v.op)
               F6Vmandn: vd[k] = v.vs2[k] & ~v.vs1[k];
               F6Vmand:  vd[k] = v.vs2[k] & v.vs1[k];
               F6Vmor:   vd[k] = v.vs2[k] | v.vs1[k];
               default:  vd[k] = v.vs2[k] ^ v.vs1[k];
            endcase
         end
      end else begin
         sew = 8 << v.sew;
         for (int e = 0; e < int'(v.vl); e++) begin
            a = 64'(v.vs2 >> (e * sew));
            b = 64'(v.vs1 >> (e * sew));
            case (v.op)
               F6Vadd:  r = a + b;
               F6Vsub:  r = a - b;
               F6Vand:  r = a & b;
               F6Vor:   r = a | b;
               default: r = a ^ b;
            endcase
            for (int k = 0; k < sew; k++) vd[e*sew + k] = r[k];
         end
      end
      return vd;
   endfunction

   function automatic vec_t mk(input int id, input logic [5:0] op, input logic msk,
                               input logic [2:0] sew, input logic [1:0] nbl,
                               input logic [VlW-1:0] vlv, input logic [VLEN-1:0] s1,
                               input logic [VLEN-1:0] s2, input logic [VLEN-1:0] old);
      vec_t v;
      v.id = id; v.op = op; v.msk = msk; v.sew = sew; v.nbl = nbl; v.vl = vlv;
      v.vs1 = s1; v.vs2 = s2; v.old = old;
      v.exp_err = ref_err(v);
      v.exp_lat = ref_lat(v);
      v.exp_vd  = ref_vd(v);
      return v;
   endfunction

   function automatic logic [VLEN-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   int   n_cmp = 0;
   int   n_fail = 0;
   vec_t sb_q[$];
   vec_t tbl[$];

   task automatic check(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      opcode = v.op; instr_mask = v.msk; vsew = v.sew; op_type = OpTypeVV;
      nb_lanes = v.nbl; vl = v.vl; vs1_in = v.vs1; vs2_in = v.vs2; vd_old = v.old;
      start = 1'b1;
   endtask

   // mode 1: extra start while running; mode 2: extra start during the final (DONE) cycle.
   task automatic do_txn(input vec_t v, input int mode);
      vec_t exp;
      int   cyc;
      @(negedge clk);
      drive(v);
      sb_q.push_back(v);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d busy", v.id), VLEN'(busy), VLEN'(1));
      cyc = 0;
      while (!done && cyc < 100) begin
         if (!alu_run) check($sformatf("v%0d idle offset", v.id), VLEN'(alu_in_reg_offset), '0);
         if ((mode == 1 && cyc == 2) || (mode == 2 && cyc == int'(v.exp_lat) - 1)) begin
            start  = 1'b1;
            vd_old = ~v.old;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL v%0d timeout: no done after %0d cycles, expected %0d", v.id, cyc,
                  v.exp_lat);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL v%0d unexpected done: got done with empty scoreboard", v.id);
      end else begin
         exp = sb_q.pop_front();
         check($sformatf("v%0d latency", exp.id), VLEN'(cyc), VLEN'(exp.exp_lat));
         check($sformatf("v%0d err", exp.id), VLEN'(err), VLEN'(exp.exp_err));
         check($sformatf("v%0d vd_out", exp.id), vd_out, exp.exp_vd);
         @(negedge clk);
         check($sformatf("v%0d done pulse", exp.id), VLEN'(done), '0);
         check($sformatf("v%0d busy after", exp.id), VLEN'(busy), '0);
         check($sformatf("v%0d vd_out held", exp.id), vd_out, exp.exp_vd);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VLEN-1:0] a, b, e;
      vec_t            v;
      int              dones;

      resetn = 1'b0; start = 1'b0; opcode = '0; instr_mask = 1'b0; vsew = '0; op_type = '0;
      nb_lanes = '0; vl = '0; vs1_in = '0; vs2_in = '0; vd_old = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("reset done", VLEN'(done), '0);
      check("reset busy", VLEN'(busy), '0);
      check("reset err", VLEN'(err), '0);
      check("reset vd_out", vd_out, '0);
      check("reset alu_run", VLEN'(alu_run), '0);
      check("reset byte_i", VLEN'(alu_byte_i), '0);
      check("reset offset", VLEN'(alu_in_reg_offset), '0);
      check("reset alu_vs1", alu_vs1, '0);
      check("reset alu_opcode", VLEN'(alu_opcode), '0);

      for (int i = 0; i < 16; i++) begin
         a[8*i +: 8] = 8'(2 * i);
         b[8*i +: 8] = 8'(i);
         e[8*i +: 8] = 8'(3 * i);
      end
      v = mk(0, F6Vadd, 1'b0, 3'd0, 2'd2, 8'd16, a, b, '0);
      v.exp_vd = e;
      v.exp_lat = 6;
      tbl.push_back(v);
      v = mk(1, F6Vadd, 1'b0, 3'd3, 2'd0, 8'd2, 128'd1, 128'h0000_0000_FFFF_FFFF, '0);
      v.exp_vd = 128'h1_0000_0000;
      v.exp_lat = 18;
      tbl.push_back(v);
      v = mk(2, F6Vmand, 1'b1, 3'd0, 2'd2, 8'd10, 128'h155, 128'h3FF, '1);
      v.exp_vd = ~128'h3FF | 128'h155;
      tbl.push_back(v);
      tbl.push_back(mk(3, F6Vor, 1'b0, 3'd1, 2'd2, 8'd3, rnd(), rnd(), {8{16'hAAAA}}));
      tbl.push_back(mk(4, 6'b111111, 1'b0, 3'd0, 2'd2, 8'd4, rnd(), rnd(), rnd()));
      tbl.push_back(mk(5, F6Vadd, 1'b0, 3'd0, 2'd2, 8'd0, rnd(), rnd(), rnd()));
      tbl.push_back(mk(6, F6Vadd, 1'b0, 3'd2, 2'd2, 8'd5, rnd(), rnd(), rnd()));
      tbl.push_back(mk(7, F6Vadd, 1'b0, 3'd0, 2'd3, 8'd4, rnd(), rnd(), rnd()));
      tbl.push_back(mk(8, F6Vadd, 1'b0, 3'd4, 2'd0, 8'd1, rnd(), rnd(), rnd()));
      tbl.push_back(mk(9, F6Vsub, 1'b0, 3'd2, 2'd1, 8'd4, rnd(), rnd(), rnd()));
      tbl.push_back(mk(10, F6Vxor, 1'b0, 3'd0, 2'd1, 8'd13, rnd(), rnd(), rnd()));
      tbl.push_back(mk(11, F6Vmxor, 1'b1, 3'd0, 2'd2, 8'd128, rnd(), rnd(), rnd()));
      tbl.push_back(mk(12, F6Vmor, 1'b1, 3'd0, 2'd2, 8'd129, rnd(), rnd(), rnd()));
      tbl.push_back(mk(13, F6Vadd, 1'b0, 3'd1, 2'd2, 8'd8, rnd(), rnd(), rnd()));
      tbl.push_back(mk(14, F6Vmandn, 1'b1, 3'd0, 2'd1, 8'd37, rnd(), rnd(), rnd()));
      tbl.push_back(mk(15, F6Vadd, 1'b0, 3'd2, 2'd0, 8'd4, {4{32'd1}}, '1, rnd()));

      foreach (tbl[i]) do_txn(tbl[i], (i == 0) ? 1 : ((i == 3) ? 2 : 0));

      // Reset in the middle of a long instruction must abort it silently.
      @(negedge clk);
      drive(tbl[1]);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("abort running", VLEN'(alu_run), VLEN'(1));
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("abort busy", VLEN'(busy), '0);
      check("abort alu_run", VLEN'(alu_run), '0);
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort stale done", VLEN'(dones), '0);
      do_txn(tbl[1], 0);
      do_txn(tbl[9], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
